// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB sharing one memory port via req/ack.
// Outputs decode from state and the latched opcode; memory strobes are qualified by mem_ack.
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mdr_write,
  output logic       branch,
  output logic       regdst,
  output logic       alusrc,
  output logic       regwrite,
  output logic       memreg,
  output logic [2:0] aluop,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [3:0] OP_R   = 4'd0;
  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_BEQ = 4'd9;

  state_t     state_q, state_d, boundary;
  logic [3:0] op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
    end
  end

  assign state    = state_q;
  assign boundary = run ? FETCH : IDLE;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mdr_write  = 1'b0;
    branch     = 1'b0;
    regdst     = 1'b0;
    alusrc     = 1'b0;
    regwrite   = 1'b0;
    memreg     = 1'b0;
    aluop      = 3'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      // op_q is not yet loaded here, so the decision uses the live opcode
      DECODE: begin
        if (opcode == OP_R || opcode == OP_LW || opcode == OP_SW || opcode == OP_BEQ) begin
          state_d = EXEC;
        end else begin
          illegal = 1'b1;
          state_d = boundary;
        end
      end
      EXEC: begin
        case (op_q)
          OP_R: begin
            aluop   = 3'd4;
            state_d = WB;
          end
          OP_LW, OP_SW: begin
            aluop   = 3'd2;
            alusrc  = 1'b1;
            state_d = MEM;
          end
          OP_BEQ: begin
            aluop      = 3'd1;
            branch     = 1'b1;
            pc_write   = zero;
            instr_done = 1'b1;
            state_d    = boundary;
          end
          default: state_d = IDLE;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        alusrc  = 1'b1;
        aluop   = 3'd2;
        mem_we  = (op_q == OP_SW);
        if (mem_ack) begin
          if (op_q == OP_SW) begin
            instr_done = 1'b1;
            state_d    = boundary;
          end else begin
            mdr_write = 1'b1;
            state_d   = WB;
          end
        end
      end
      WB: begin
        regwrite   = 1'b1;
        regdst     = (op_q == OP_R);
        memreg     = (op_q == OP_LW);
        instr_done = 1'b1;
        state_d    = boundary;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle expected state and packed control vector.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n, run, zero, mem_ack;
  logic [3:0] opcode;
  logic       mem_req, mem_we, iord, ir_write, pc_write, mdr_write, branch;
  logic       regdst, alusrc, regwrite, memreg, instr_done, illegal;
  logic [2:0] aluop, state;

  int npass = 0;
  int ntotal = 0;

  localparam logic [15:0] REQ  = 16'h8000;
  localparam logic [15:0] WE   = 16'h4000;
  localparam logic [15:0] IORD = 16'h2000;
  localparam logic [15:0] IRW  = 16'h1000;
  localparam logic [15:0] PCW  = 16'h0800;
  localparam logic [15:0] MDRW = 16'h0400;
  localparam logic [15:0] BR   = 16'h0200;
  localparam logic [15:0] RD   = 16'h0100;
  localparam logic [15:0] SRC  = 16'h0080;
  localparam logic [15:0] RW   = 16'h0040;
  localparam logic [15:0] MR   = 16'h0020;
  localparam logic [15:0] ALU1 = 16'h0004;
  localparam logic [15:0] ALU2 = 16'h0008;
  localparam logic [15:0] ALU4 = 16'h0010;
  localparam logic [15:0] DONE = 16'h0002;
  localparam logic [15:0] ILL  = 16'h0001;

  localparam logic [15:0] FETCH_OK = REQ | IRW | PCW;
  localparam logic [15:0] MEM_LW   = REQ | IORD | SRC | ALU2;

  wire [15:0] ctl = {mem_req, mem_we, iord, ir_write, pc_write, mdr_write, branch,
                     regdst, alusrc, regwrite, memreg, aluop, instr_done, illegal};

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .mdr_write(mdr_write),
    .branch(branch), .regdst(regdst), .alusrc(alusrc), .regwrite(regwrite),
    .memreg(memreg), .aluop(aluop), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive inputs just after an edge, check mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic run_i, input logic ack_i,
                      input logic [3:0] op_i, input logic zero_i,
                      input logic [2:0] exp_st, input logic [15:0] exp_ctl);
    run = run_i; mem_ack = ack_i; opcode = op_i; zero = zero_i;
    #3;
    chk({tag, ".state"}, {13'd0, state}, {13'd0, exp_st});
    chk({tag, ".ctl"}, ctl, exp_ctl);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; opcode = 4'd0; zero = 1'b0;
    @(posedge clk); #1;
    chk("reset.state", {13'd0, state}, 16'd0);
    chk("reset.ctl", ctl, 16'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    step("idle0",     1, 1, 4'd0, 0, 3'd0, 16'd0);
    // R-type, zero wait
    step("r.fetch",   1, 1, 4'd0, 0, 3'd1, FETCH_OK);
    step("r.decode",  1, 1, 4'd0, 0, 3'd2, 16'd0);
    step("r.exec",    1, 1, 4'd0, 0, 3'd3, ALU4);
    step("r.wb",      1, 1, 4'd0, 0, 3'd5, RW | RD | DONE);
    // LW, two wait cycles in FETCH and MEM
    step("lw.fetchw1", 1, 0, 4'd1, 0, 3'd1, REQ);
    step("lw.fetchw2", 1, 0, 4'd1, 0, 3'd1, REQ);
    step("lw.fetch",   1, 1, 4'd1, 0, 3'd1, FETCH_OK);
    step("lw.decode",  1, 1, 4'd1, 0, 3'd2, 16'd0);
    step("lw.exec",    1, 1, 4'd0, 0, 3'd3, ALU2 | SRC);
    step("lw.memw1",   1, 0, 4'd0, 0, 3'd4, MEM_LW);
    step("lw.memw2",   1, 0, 4'd0, 0, 3'd4, MEM_LW);
    step("lw.mem",     1, 1, 4'd0, 0, 3'd4, MEM_LW | MDRW);
    step("lw.wb",      1, 1, 4'd0, 0, 3'd5, RW | MR | DONE);
    // SW, opcode port changes after DECODE must not matter
    step("sw.fetch",   1, 1, 4'd8, 0, 3'd1, FETCH_OK);
    step("sw.decode",  1, 1, 4'd8, 0, 3'd2, 16'd0);
    step("sw.exec",    1, 1, 4'd0, 0, 3'd3, ALU2 | SRC);
    step("sw.mem",     1, 1, 4'd1, 0, 3'd4, MEM_LW | WE | DONE);
    // BEQ taken then not taken
    step("beq1.fetch", 1, 1, 4'd9, 1, 3'd1, FETCH_OK);
    step("beq1.decode",1, 1, 4'd9, 1, 3'd2, 16'd0);
    step("beq1.exec",  1, 1, 4'd9, 1, 3'd3, ALU1 | BR | PCW | DONE);
    step("beq0.fetch", 1, 1, 4'd9, 0, 3'd1, FETCH_OK);
    step("beq0.decode",1, 1, 4'd9, 0, 3'd2, 16'd0);
    step("beq0.exec",  1, 1, 4'd9, 0, 3'd3, ALU1 | BR | DONE);
    // Illegal opcode
    step("ill.fetch",  1, 1, 4'd5, 0, 3'd1, FETCH_OK);
    step("ill.decode", 1, 1, 4'd5, 0, 3'd2, ILL);
    // R-type with run dropped in EXEC
    step("rd.fetch",   1, 1, 4'd0, 0, 3'd1, FETCH_OK);
    step("rd.decode",  1, 1, 4'd0, 0, 3'd2, 16'd0);
    step("rd.exec",    0, 1, 4'd0, 0, 3'd3, ALU4);
    step("rd.wb",      0, 1, 4'd0, 0, 3'd5, RW | RD | DONE);
    step("rd.idle1",   0, 1, 4'd0, 0, 3'd0, 16'd0);
    step("rd.idle2",   0, 1, 4'd0, 0, 3'd0, 16'd0);
    // LW interrupted by reset during a MEM wait
    step("rst.idle",   1, 1, 4'd1, 0, 3'd0, 16'd0);
    step("rst.fetch",  1, 1, 4'd1, 0, 3'd1, FETCH_OK);
    step("rst.decode", 1, 1, 4'd1, 0, 3'd2, 16'd0);
    step("rst.exec",   1, 1, 4'd1, 0, 3'd3, ALU2 | SRC);
    run = 1'b1; mem_ack = 1'b0;
    #2;
    chk("rst.memwait.state", {13'd0, state}, 16'd4);
    chk("rst.memwait.ctl", ctl, MEM_LW);
    rst_n = 1'b0;
    #1;
    chk("rst.async.state", {13'd0, state}, 16'd0);
    chk("rst.async.ctl", ctl, 16'd0);
    run = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step("post.idle1", 0, 1, 4'd0, 0, 3'd0, 16'd0);
    step("post.idle2", 0, 1, 4'd0, 0, 3'd0, 16'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
